arbmux: RTL and testbench

Round-robin, packet-aware arbiter sharing one DW-bit output channel among N valid/ready requesters. Generates the one-hot select for the existing one-hot mux, holds the grant for the whole packet (until a `last` beat), and registers the selected beat in a one-entry output stage. It sits upstream of any single-consumer datapath fed by multiple sources.

---
 rtl/arbmux_pkg.sv | 9 +
 rtl/muxhot.sv | 18 +
 rtl/arbmux.sv | 96 +++++++++
 tb/tb_arbmux.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/arbmux_pkg.sv
// Shared encodings for the round-robin packet arbiter.
package arbmux_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/muxhot.sv
// One-hot AND-OR multiplexer: selects the DW-bit slice whose sel bit is set.
module muxhot #(
  parameter int DW = 8,
  parameter int N  = 8
) (
  input  logic [N-1:0]    sel,
  input  logic [N*DW-1:0] slices,
  output logic [DW-1:0]   result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < N; i++) begin
      result = result | (slices[i*DW +: DW] & {DW{sel[i]}});
    end
  end

endmodule

// File: rtl/arbmux.sv
// Round-robin packet-aware arbiter: grants one requester per packet and
// registers the selected beat into a one-entry output stage.
module arbmux
  import arbmux_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic [N-1:0]    grant,
  output logic            locked
);

  arb_state_t          state, state_nxt;
  logic [N-1:0]        owner;
  logic [N-1:0]        ptr;
  logic [N-1:0]        rr_grant;
  logic [2*N-1:0]      dbl;
  logic [2*N-1:0]      dbl_low;
  logic [N*(DW+1)-1:0] mux_slices;
  logic [DW:0]         sel_beat;
  logic                adv;
  logic                xfer;
  logic                sel_last;

  // Requests at or above ptr in the low half, all requests in the high half;
  // the lowest set bit of the pair is the next requester in rotation order.
  always_comb begin
    dbl      = {in_valid, in_valid & (-ptr)};
    dbl_low  = dbl & (-dbl);
    rr_grant = dbl_low[N-1:0] | dbl_low[2*N-1:N];
  end

  assign grant    = (state == ARB_LOCK) ? owner : rr_grant;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = grant & {N{adv & nreset}};
  assign xfer     = |(in_valid & in_ready);
  assign locked   = (state == ARB_LOCK);

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign mux_slices[i*(DW+1) +: DW+1] = {in_last[i], in_data[i*DW +: DW]};
  end

  muxhot #(
    .DW (DW + 1),
    .N  (N)
  ) u_muxhot (
    .sel    (grant),
    .slices (mux_slices),
    .result (sel_beat)
  );

  assign sel_last = sel_beat[DW];

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (xfer && !sel_last) state_nxt = ARB_LOCK;
      ARB_LOCK: if (xfer && sel_last)  state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      ptr       <= {{(N-1){1'b0}}, 1'b1};
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer && (state == ARB_IDLE) && !sel_last) owner <= grant;
      // Rotation restarts just past the requester whose packet finished.
      if (xfer && sel_last) ptr <= (grant << 1) | (grant >> (N - 1));
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_beat[DW-1:0];
        out_last  <= sel_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbmux.sv
// Directed bench for arbmux with a queue scoreboard on the output channel.
module tb_arbmux;
  localparam int DW = 8;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            nreset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            locked;

  logic [DW:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  arbmux #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .locked    (locked)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int i, input logic [7:0] d, input logic l);
    in_data[i*DW +: DW] = d;
    in_last[i] = l;
  endtask

  // Output monitor: a beat is consumed at the next edge when valid & ready.
  always @(negedge clk) begin
    if (nreset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got %0h expected none", {out_last, out_data});
      end else begin
        chk("out_beat", {23'b0, out_last, out_data}, {23'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nreset    = 1'b0;
    out_ready = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    in_last   = '0;
    for (int i = 0; i < N; i++) setd(i, 8'h10 + 8'(i), 1'b1);

    // Reset held with everyone requesting
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    nreset = 1'b1;

    // Fairness: single-beat packets rotate 0..7 then 0
    for (int i = 0; i < 9; i++) exp_q.push_back({1'b1, 8'h10 + 8'(i % N)});
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'h01);
    tick();
    repeat (8) tick();
    in_valid = '0;
    repeat (3) tick();

    // Packet lock: requester 2 four beats, requester 5 waiting
    in_valid = 8'h24;
    setd(5, 8'h50, 1'b1);
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back({b == 3, 8'h20 + 8'(b)});
      setd(2, 8'h20 + 8'(b), b == 3);
      @(negedge clk);
      chk("lock_grant", 32'(grant), 32'h04);
      if (b > 0) chk("lock_locked", 32'(locked), 32'd1);
      tick();
    end
    exp_q.push_back({1'b1, 8'h50});
    @(negedge clk);
    chk("lock_released", 32'(locked), 32'd0);
    chk("lock_next_grant", 32'(grant), 32'h20);
    tick();
    in_valid = '0;
    repeat (3) tick();

    // Mid-packet gap: owner 3 idles, requester 6 must wait
    in_valid = 8'h08;
    setd(3, 8'h30, 1'b0);
    exp_q.push_back({1'b0, 8'h30});
    tick();
    in_valid = 8'h40;
    setd(6, 8'h61, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("gap_grant", 32'(grant), 32'h08);
      chk("gap_ready6", 32'(in_ready[6]), 32'd0);
      chk("gap_out_valid", 32'(out_valid), (k == 0) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 8'h48;
    setd(3, 8'h31, 1'b1);
    exp_q.push_back({1'b1, 8'h31});
    @(negedge clk);
    chk("gap_resume_grant", 32'(grant), 32'h08);
    tick();
    exp_q.push_back({1'b1, 8'h61});
    @(negedge clk);
    chk("gap_after_grant", 32'(grant), 32'h40);
    tick();
    in_valid = '0;
    repeat (3) tick();

    // Backpressure: output stalled for five cycles
    in_valid = 8'h81;
    setd(7, 8'h70, 1'b1);
    setd(0, 8'h0A, 1'b1);
    exp_q.push_back({1'b1, 8'h70});
    exp_q.push_back({1'b1, 8'h0A});
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h70);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_grant", 32'(grant), 32'h01);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'h01);
    tick();
    in_valid = '0;
    repeat (3) tick();

    // Reset during a requester-1 packet
    in_valid = 8'h02;
    setd(1, 8'h1B, 1'b0);
    exp_q.push_back({1'b0, 8'h1B});
    tick();
    tick();
    nreset   = 1'b0;
    in_valid = 8'h03;
    setd(0, 8'h0C, 1'b1);
    setd(1, 8'h1C, 1'b1);
    repeat (2) tick();
    nreset = 1'b1;
    exp_q.push_back({1'b1, 8'h0C});
    @(negedge clk);
    chk("mrst_locked", 32'(locked), 32'd0);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_grant", 32'(grant), 32'h01);
    tick();
    in_valid = '0;
    repeat (3) tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
